// File: rtl/uart_pkg.sv
// Shared types and elaboration helpers for the oversampling UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4,
    ST_BRK   = 3'd5
  } rx_state_t;

  // Bits needed to count 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Legal parameter space: 5..9 data bits, even OVS >= 8, stop time of at least one bit.
  function automatic bit rx_cfg_ok(input int dbit, input int ovs, input int sb_tick);
    return (dbit >= 5) && (dbit <= 9) && (ovs >= 8) && (ovs % 2 == 0) && (sb_tick >= ovs);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line conditioning: 2-flop synchroniser plus 3-sample majority vote.
// Two samples are registered; the third is the live synchronised value, so
// vote is already the full majority on the tick that takes the last sample.
module uart_rx_sampler (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  input  logic en,
  output logic rx_s,
  output logic vote
);

  logic [1:0] sync_q;
  logic [1:0] tap_q;

  // Synchronise the asynchronous pad input; idle-high after reset.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx};
  end

  assign rx_s = sync_q[1];

  // Capture the first two samples of the vote window.
  always_ff @(posedge clk) begin
    if (reset)   tap_q <= 2'b11;
    else if (en) tap_q <= {tap_q[0], rx_s};
  end

  assign vote = (tap_q[1] & tap_q[0]) | (tap_q[1] & rx_s) | (tap_q[0] & rx_s);

endmodule

// File: rtl/uart_rx_ext.sv
// Oversampling UART receiver: configurable width, optional parity, majority
// voting, false-start rejection and framing/parity/break reporting.
import uart_pkg::*;

module uart_rx_ext #(
  parameter int DBIT       = 8,
  parameter int OVS        = 16,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic            rx_done_tick,
  output logic [DBIT-1:0] dout,
  output logic            parity_err,
  output logic            frame_err,
  output logic            break_det
);

  if (!rx_cfg_ok(DBIT, OVS, SB_TICK)) begin : g_bad_cfg
    $error("uart_rx_ext: illegal DBIT/OVS/SB_TICK combination");
  end

  localparam int SW = clog2(max2(OVS, SB_TICK));
  localparam int NW = clog2(DBIT);
  localparam logic [SW-1:0] S_HALF  = SW'(OVS/2 - 1);
  localparam logic [SW-1:0] S_VOTE0 = SW'(OVS - 3);
  localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP  = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

  rx_state_t       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d, dout_d;
  logic            p_q, p_d, stop_q, stop_d;
  logic            perr_d, ferr_d, brk_d;
  logic            rx_s, vote, stop_bit, is_brk, samp_en;

  // Last three ticks of each bit window feed the voter.
  assign samp_en = s_tick & (s_q >= S_VOTE0) & (s_q <= S_LAST);

  uart_rx_sampler u_sampler (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .en    (samp_en),
    .rx_s  (rx_s),
    .vote  (vote)
  );

  // State, counters, shift register and committed outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      p_q        <= 1'b0;
      stop_q     <= 1'b0;
      dout       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      p_q        <= p_d;
      stop_q     <= stop_d;
      dout       <= dout_d;
      parity_err <= perr_d;
      frame_err  <= ferr_d;
      break_det  <= brk_d;
    end
  end

  // Frame sequencing; commit happens on the last stop tick and raises the done pulse.
  always_comb begin
    state_d      = state_q;
    s_d          = s_q;
    n_d          = n_q;
    b_d          = b_q;
    p_d          = p_q;
    stop_d       = stop_q;
    dout_d       = dout;
    perr_d       = parity_err;
    ferr_d       = frame_err;
    brk_d        = break_det;
    rx_done_tick = 1'b0;
    // With SB_TICK == OVS the stop vote and the commit share one tick.
    stop_bit     = (s_q == S_LAST) ? vote : stop_q;
    is_brk       = (b_q == '0) & (~p_q | ~PARITY_EN) & ~stop_bit;

    case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_HALF) begin
            s_d = '0;
            if (rx_s) state_d = ST_IDLE;
            else begin
              state_d = ST_DATA;
              n_d     = '0;
            end
          end else s_d = s_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {vote, b_q[DBIT-1:1]};
            if (n_q == N_LAST) state_d = PARITY_EN ? ST_PAR : ST_STOP;
            else               n_d     = n_q + 1'b1;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_PAR: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d     = '0;
            p_d     = vote;
            state_d = ST_STOP;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_LAST) stop_d = vote;
          if (s_q == S_STOP) begin
            s_d          = '0;
            dout_d       = b_q;
            ferr_d       = ~stop_bit;
            perr_d       = PARITY_EN & (^b_q ^ p_q ^ PARITY_ODD);
            brk_d        = is_brk;
            rx_done_tick = 1'b1;
            state_d      = is_brk ? ST_BRK : ST_IDLE;
          end else s_d = s_q + 1'b1;
        end
      end
      ST_BRK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Bench for uart_rx_ext: an 8N1 instance (a) and an 8E1 instance (b) share clock,
// reset and tick; each has its own line. Expected results are derived per frame
// from the transmitted bits and checked whenever a done pulse appears.
module tb_uart_rx_ext;

  localparam int BIT = 64; // clocks per bit: 16 ticks x 4 clocks

  typedef struct packed {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
    logic       brk;
  } res_t;

  logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, rx_a = 1'b1, rx_b = 1'b1;
  logic done_a, done_b, perr_a, perr_b, ferr_a, ferr_b, brk_a, brk_b;
  logic [7:0] dout_a, dout_b;

  res_t q_a[$], q_b[$];
  res_t held_a = '0, held_b = '0;
  int pass_cnt = 0, total_cnt = 0, pulses_a = 0, pulses_b = 0;

  uart_rx_ext #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .s_tick(s_tick), .rx_done_tick(done_a),
    .dout(dout_a), .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a));

  uart_rx_ext #(.DBIT(8), .OVS(16), .SB_TICK(16), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .s_tick(s_tick), .rx_done_tick(done_b),
    .dout(dout_b), .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b));

  always #5 clk = ~clk;

  // One s_tick every 4 clocks.
  initial begin
    int ph;
    ph = 0;
    forever begin
      @(posedge clk); #1;
      s_tick = (ph == 3);
      ph = (ph + 1) % 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int which, input logic v);
    if (which == 0) rx_a = v;
    else            rx_b = v;
  endtask

  // What a receiver must report for a frame, from the bits put on the line.
  function automatic res_t model(input int which, input logic [7:0] d, input logic pbit,
                                 input logic stop_hi);
    res_t r;
    bit pe;
    pe     = (which == 1);
    r.d    = d;
    r.ferr = !stop_hi;
    r.perr = pe && ($countones({d, pbit}) % 2 == 1); // even parity: total ones even
    r.brk  = (d == 8'h00) && (!pe || !pbit) && !stop_hi;
    return r;
  endfunction

  // Drive one frame LSB first; a low stop bit is held low past its sampling point only.
  task automatic send(input int which, input logic [7:0] d, input logic pbit,
                      input logic stop_hi, input int glitch_bit, input int gap_bits);
    if (which == 0) q_a.push_back(model(which, d, pbit, stop_hi));
    else            q_b.push_back(model(which, d, pbit, stop_hi));
    set_line(which, 1'b0); clks(BIT);
    for (int i = 0; i < 8; i++) begin
      set_line(which, d[i]);
      if (i == glitch_bit) begin
        clks(28); set_line(which, !d[i]); clks(4); set_line(which, d[i]); clks(BIT - 32);
      end else clks(BIT);
    end
    if (which == 1) begin set_line(which, pbit); clks(BIT); end
    set_line(which, stop_hi);
    if (stop_hi) clks(BIT);
    else begin clks(44); set_line(which, 1'b1); clks(BIT - 44); end
    set_line(which, 1'b1);
    clks(gap_bits * BIT);
  endtask

  // Cycle compare: outputs must hold the last committed frame; each pulse consumes one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        held_a = '0; held_b = '0;
        q_a.delete(); q_b.delete();
      end else begin
        chk("hold_a", {dout_a, perr_a, ferr_a, brk_a}, held_a);
        chk("hold_b", {dout_b, perr_b, ferr_b, brk_b}, held_b);
        if (done_a) begin
          pulses_a++;
          chk("frame_pending_a", 32'(q_a.size() != 0), 1);
          if (q_a.size() != 0) held_a = q_a.pop_front();
        end
        if (done_b) begin
          pulses_b++;
          chk("frame_pending_b", 32'(q_b.size() != 0), 1);
          if (q_b.size() != 0) held_b = q_b.pop_front();
        end
      end
    end
  end

  initial begin
    int p0;
    logic [7:0] d;
    logic pb, sh;
    reset = 1'b1; clks(4); reset = 1'b0; clks(2);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_flags_a", {perr_a, ferr_a, brk_a}, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_dout_b", dout_b, 0);

    // 8N1 basic frame
    p0 = pulses_a;
    send(0, 8'hA5, 1'b0, 1'b1, -1, 2);
    chk("t1_pulses", pulses_a - p0, 1);
    chk("t1_dout", dout_a, 8'hA5);
    chk("t1_flags", {perr_a, ferr_a, brk_a}, 0);

    // even parity: 0x07 needs parity bit 1
    send(1, 8'h07, 1'b0, 1'b1, -1, 2);
    chk("t2_dout", dout_b, 8'h07);
    chk("t2_perr_bad", perr_b, 1);
    send(1, 8'h07, 1'b1, 1'b1, -1, 2);
    chk("t2_perr_good", perr_b, 0);

    // framing error, then a clean frame
    send(0, 8'h55, 1'b0, 1'b0, -1, 2);
    chk("t4_dout", dout_a, 8'h55);
    chk("t4_ferr", ferr_a, 1);
    chk("t4_brk", brk_a, 0);
    send(0, 8'h3C, 1'b0, 1'b1, -1, 2);
    chk("t4_ferr_clear", ferr_a, 0);

    // false start: 5 ticks low
    p0 = pulses_a;
    rx_a = 1'b0; clks(20); rx_a = 1'b1; clks(2 * BIT);
    chk("t3_pulses", pulses_a - p0, 0);
    chk("t3_dout_held", dout_a, 8'h3C);
    chk("t3_flags_held", {perr_a, ferr_a, brk_a}, 0);

    // line break for 20 bit times, then 0x41
    p0 = pulses_a;
    q_a.push_back(model(0, 8'h00, 1'b0, 1'b0));
    rx_a = 1'b0; clks(20 * BIT);
    chk("t5_pulses_low", pulses_a - p0, 1);
    chk("t5_dout", dout_a, 0);
    chk("t5_ferr_brk", {ferr_a, brk_a}, 2'b11);
    rx_a = 1'b1; clks(2 * BIT);
    send(0, 8'h41, 1'b0, 1'b1, -1, 2);
    chk("t5_pulses", pulses_a - p0, 2);
    chk("t5_dout_next", dout_a, 8'h41);
    chk("t5_flags_next", {perr_a, ferr_a, brk_a}, 0);

    // glitch at a data-bit midpoint
    send(0, 8'hFF, 1'b0, 1'b1, 3, 2);
    chk("t6_glitch_dout", dout_a, 8'hFF);

    // reset in the middle of data bits
    p0 = pulses_a;
    rx_a = 1'b0; clks(3 * BIT);
    reset = 1'b1; clks(3);
    rx_a = 1'b1; reset = 1'b0; clks(1);
    chk("t6_rst_dout", dout_a, 0);
    chk("t6_rst_flags", {perr_a, ferr_a, brk_a}, 0);
    clks(2 * BIT);
    chk("t6_rst_pulses", pulses_a - p0, 0);
    send(0, 8'h12, 1'b0, 1'b1, -1, 2);
    chk("t6_after_rst", dout_a, 8'h12);

    // randomized frames on both receivers
    for (int k = 0; k < 15; k++) begin
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sh = ($urandom_range(0, 4) != 0);
      send(0, d, 1'b0, sh, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
           int'($urandom_range(2, 4)));
      d  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      sh = ($urandom_range(0, 4) != 0);
      pb = (^d) ^ ($urandom_range(0, 3) == 0);
      send(1, d, pb, sh, -1, int'($urandom_range(2, 4)));
    end

    clks(2 * BIT);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
